theta_sincos_gen64: RTL
=======================

# theta_sincos_gen64

Phase accumulator and quarter-wave sine/cosine generator that produces the 64-bit IEEE-754 double `sin_theta`/`cos_theta` pair consumed by the dq0→abc transform stage. On each `sta` pulse it looks up sine and cosine for the current electrical angle, then advances the angle by a per-step increment. It raises `done_sig` when the pair is valid. It sits directly upstream of the dq0→abc block in the per-timestep solver chain.

## Interface
- `PHASE_W`, 32: phase word width; 2^PHASE_W represents 2π.
- `LUT_AW`, 10: quarter-wave address width; ROM depth is 2^LUT_AW+1.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `sta` in 1: single-cycle start; request one sample.
- `load` in 1: synchronous load of the phase accumulator.
- `phase_init` in PHASE_W: value loaded when `load`=1.
- `dphase` in PHASE_W: unsigned angle increment per `sta`.
- `sin_theta` out `EXTENDED_SINGLE` (64): sin of the sampled angle, double.
- `cos_theta` out 64: cos of the sampled angle, double.
- `theta_phase` out PHASE_W: phase word that produced the current outputs.
- `done_sig` out 1: one-cycle pulse; outputs updated this cycle.

## Operation
- Accumulator `acc` is PHASE_W bits wide and wraps modulo 2^PHASE_W. There is no saturation.
- On `sta`, the sampled phase `p` = `acc`, and `acc` becomes `p + dphase` (post-increment). The first sample after reset is therefore angle 0.
- On `load`, `acc` becomes `phase_init`.
- If `load` and `sta` are both high in the same cycle, load has priority: `p` = `phase_init` and `acc` becomes `phase_init + dphase`.
- Sine lookup uses `p`. Cosine lookup uses `p + 2^(PHASE_W-2)` (+π/2).
- Each lookup is decoded as follows:
  - Quadrant `q` = the top 2 bits of the phase.
  - `k` = the next LUT_AW bits. Lower bits are truncated; there is no interpolation.
  - ROM index is `k` for q=0,2 and 2^LUT_AW−`k` for q=1,3.
  - ROM entry i holds the double value sin(i·π/2^(LUT_AW+1)). Entry 0 is +0.0 and entry 2^LUT_AW is 1.0.
- Sign: bit 63 of the ROM word is inverted for q=2,3. The exception is a zero magnitude (entry 0), which always outputs 0x0000000000000000; the block never outputs −0.0.
- Requests are fully pipelined and one `sta` per cycle is accepted. `sta` while earlier requests are in flight is legal.
- Outputs hold their last value until the next `done_sig`.
- Reset values: `acc`=0, `sin_theta`=0, `cos_theta`=0, `theta_phase`=0, `done_sig`=0. All pipeline valid bits are cleared.

## Timing
- Pipeline stages:
  - Cycle 1: `p` registered.
  - Cycle 2: quadrant, index and sign registered.
  - Cycle 3: ROM synchronous read.
  - Cycle 4: sign applied, outputs registered.
- `done_sig` asserts exactly 4 cycles after `sta`, in the same cycle the outputs change.
- Back-to-back `sta` for N cycles gives N consecutive `done_sig` pulses with results in order.
- Asserting `rst` mid-pipeline drops in-flight samples. No `done_sig` appears after reset release unless a new `sta` is issued.
- `dphase` and `phase_init` are sampled only in the `sta`/`load` cycle.

## Structure
- The width macro `EXTENDED_SINGLE` and constants (`ONE_DOUBLE` 0x3FF0000000000000, quadrant offset 2^(PHASE_W-2)) belong in the shared global parameter include.
- Sub-module `quarter_sine_rom64`: 2^LUT_AW+1 × 64 ROM, two synchronous read ports (sine, cosine), initialised from a generated hex file.
- `done_sig` is a 4-deep shift of `sta` held in the same reset domain.

## Test plan
- Reset, then `dphase`=0x40000000 with four `sta` pulses → (sin, cos) = (0x0, 0x3FF0000000000000), (0x3FF0000000000000, 0x0), (0x0, 0xBFF0000000000000), (0xBFF0000000000000, 0x0). Each `done_sig` arrives 4 cycles after its `sta`.
- `load` with `phase_init`=0x20000000 and `sta` in the same cycle → `sin_theta` = `cos_theta` = 0x3FE6A09E667F3BCD, `theta_phase`=0x20000000, `acc`=0x20000000+`dphase`.
- `load` 0xC0000000 with `dphase`=0x40000000, then two `sta` pulses → sample phases 0xC0000000 then 0x00000000 (wrap); second `cos_theta`=0x3FF0000000000000.
- `sta` held high for 8 cycles with `dphase`=0x10000000 → 8 consecutive `done_sig` pulses; `theta_phase` reads 0x00000000 … 0x70000000 in order.
- `sta`, then `rst` low at cycle 2 → all outputs 0, no `done_sig` ever appears, `acc`=0 after release.
- Phase 0x80000000 → `sin_theta`=0x0 (not 0x8000000000000000), `cos_theta`=0xBFF0000000000000.

Source files
------------

// File: rtl/theta_sincos_gen64_pkg.sv
`default_nettype none
// ============================================================================
// Module : theta_sincos_gen64_pkg
// Shared widths, double constants and quarter-wave ROM content helper.
// Rev    : 1.0
// ============================================================================
package theta_sincos_gen64_pkg;

  localparam int                         EXTENDED_SINGLE = 64;
  localparam logic [EXTENDED_SINGLE-1:0] ONE_DOUBLE      = 64'h3FF0_0000_0000_0000;
  localparam int                         QUAD_BITS       = 2;
  localparam real                        PI              = 3.14159265358979323846;

  // Upper half of the table comes from the cosine of the complementary angle so the
  // argument stays at or below pi/4 and the midpoint lands on the rounded sqrt(2)/2.
  function automatic logic [EXTENDED_SINGLE-1:0] rom_entry_bits(input int idx, input int aw);
    int full;
    full = 1 << aw;
    if (2 * idx >= full)
      return $realtobits($cos(real'(full - idx) * PI / real'(2 * full)));
    return $realtobits($sin(real'(idx) * PI / real'(2 * full)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/theta_sincos_gen64_rom.sv
`default_nettype none
// ============================================================================
// Module : quarter_sine_rom64
// Quarter-wave sine table of (2^LUT_AW)+1 doubles, two synchronous read ports.
// Rev    : 1.0
// ============================================================================
module quarter_sine_rom64
  import theta_sincos_gen64_pkg::*;
#(
  parameter int LUT_AW = 10
) (
  input  logic                       clk,
  input  logic [LUT_AW:0]            sin_addr_i,
  input  logic [LUT_AW:0]            cos_addr_i,
  output logic [EXTENDED_SINGLE-1:0] sin_data_o,
  output logic [EXTENDED_SINGLE-1:0] cos_data_o
);

  localparam int DEPTH = (1 << LUT_AW) + 1;

  logic [EXTENDED_SINGLE-1:0] rom [DEPTH];
  logic [EXTENDED_SINGLE-1:0] sin_data_q;
  logic [EXTENDED_SINGLE-1:0] cos_data_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic [EXTENDED_SINGLE-1:0] WORD = rom_entry_bits(gi, LUT_AW);
    assign rom[gi] = WORD;
  end

  always_ff @(posedge clk) begin
    sin_data_q <= rom[sin_addr_i];
    cos_data_q <= rom[cos_addr_i];
  end

  assign sin_data_o = sin_data_q;
  assign cos_data_o = cos_data_q;

endmodule
`default_nettype wire

// File: rtl/theta_sincos_gen64.sv
`default_nettype none
// ============================================================================
// Module : theta_sincos_gen64
// Phase accumulator with 4-stage quarter-wave sin/cos lookup producing doubles.
// Rev    : 1.0
// ============================================================================
module theta_sincos_gen64
  import theta_sincos_gen64_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sta,
  input  logic                       load,
  input  logic [PHASE_W-1:0]         phase_init,
  input  logic [PHASE_W-1:0]         dphase,
  output logic [EXTENDED_SINGLE-1:0] sin_theta,
  output logic [EXTENDED_SINGLE-1:0] cos_theta,
  output logic [PHASE_W-1:0]         theta_phase,
  output logic                       done_sig
);

  localparam int                  TOP_W     = LUT_AW + QUAD_BITS;
  localparam logic [LUT_AW:0]     FULL_IDX  = {1'b1, {LUT_AW{1'b0}}};
  // Quadrant offset expressed on the decoded top bits only; its lower bits are zero.
  localparam logic [TOP_W-1:0]    QUAD_STEP = {2'b01, {LUT_AW{1'b0}}};
  localparam int                  SB        = EXTENDED_SINGLE - 1;

  logic [PHASE_W-1:0]         acc_q, acc_d, samp_d;
  logic [3:0]                 vld_q;
  logic [PHASE_W-1:0]         p1_q, p2_q, p3_q;
  logic [TOP_W-1:0]           sin_dec_d, cos_dec_d;
  logic [TOP_W-1:0]           sin_dec_q, cos_dec_q;
  logic                       sin_neg3_q, cos_neg3_q;
  logic [EXTENDED_SINGLE-1:0] sin_rom, cos_rom;
  logic [EXTENDED_SINGLE-1:0] sin_q, cos_q;
  logic [PHASE_W-1:0]         theta_q;

  // Returns {negate, rom_index}; a zero-magnitude entry is never negated.
  function automatic logic [TOP_W-1:0] decode(input logic [TOP_W-1:0] top);
    logic [LUT_AW:0] idx;
    idx = top[LUT_AW] ? FULL_IDX - {1'b0, top[LUT_AW-1:0]} : {1'b0, top[LUT_AW-1:0]};
    return {top[TOP_W-1] && (idx != '0), idx};
  endfunction

  always_comb begin
    samp_d = load ? phase_init : acc_q;
    acc_d  = acc_q;
    if (load) acc_d = phase_init;
    if (sta)  acc_d = samp_d + dphase;
    sin_dec_d = decode(p1_q[PHASE_W-1 -: TOP_W]);
    cos_dec_d = decode(p1_q[PHASE_W-1 -: TOP_W] + QUAD_STEP);
  end

  quarter_sine_rom64 #(
    .LUT_AW     (LUT_AW)
  ) u_rom (
    .clk        (clk),
    .sin_addr_i (sin_dec_q[LUT_AW:0]),
    .cos_addr_i (cos_dec_q[LUT_AW:0]),
    .sin_data_o (sin_rom),
    .cos_data_o (cos_rom)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      vld_q      <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      p3_q       <= '0;
      sin_dec_q  <= '0;
      cos_dec_q  <= '0;
      sin_neg3_q <= 1'b0;
      cos_neg3_q <= 1'b0;
      sin_q      <= '0;
      cos_q      <= '0;
      theta_q    <= '0;
    end else begin
      acc_q      <= acc_d;
      vld_q      <= {vld_q[2:0], sta};
      p1_q       <= samp_d;
      p2_q       <= p1_q;
      sin_dec_q  <= sin_dec_d;
      cos_dec_q  <= cos_dec_d;
      p3_q       <= p2_q;
      sin_neg3_q <= sin_dec_q[TOP_W-1];
      cos_neg3_q <= cos_dec_q[TOP_W-1];
      if (vld_q[2]) begin
        sin_q   <= {sin_rom[SB] ^ sin_neg3_q, sin_rom[SB-1:0]};
        cos_q   <= {cos_rom[SB] ^ cos_neg3_q, cos_rom[SB-1:0]};
        theta_q <= p3_q;
      end
    end
  end

  assign sin_theta   = sin_q;
  assign cos_theta   = cos_q;
  assign theta_phase = theta_q;
  assign done_sig    = vld_q[3];

endmodule
`default_nettype wire
